fft_iter_engine: RTL and testbench

// Parametrised iterative radix-2 DIT FFT/IFFT engine. It generalises the fixed 32-point stage cascade to N = 2**LOG2N points.
// - One shared butterfly, one N-entry complex working store, valid/ready streaming in and out.
// - Per-frame forward/inverse select and a sticky saturation flag.
// - Sits between the sample framer and the spectral post-processing blocks.

---
 rtl/fft_iter_engine.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_fft_iter_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_iter_engine.sv
// -----------------------------------------------------------------------------
// fft_iter_engine
// Iterative radix-2 decimation-in-time FFT/IFFT engine for N = 2**LOG2N points.
// Samples stream in (natural order) and are stored bit-reversed. One shared
// butterfly then runs LOG2N*N/2 cycles in place, and the bins stream out in
// natural order.
//
// Parameters
//   LOG2N    log2 of the transform size (3..10)
//   bits     width of each real/imag component, two's complement
//   fix_bit  fractional bits of samples and twiddles
//
// Ports
//   clk_100    in   sole clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   input sample valid
//   in_ready   out  engine accepts a sample (LOAD only)
//   in_data    in   {real, imag} input sample
//   in_inv     in   sampled with the first sample of a frame: 1 = IFFT
//   out_valid  out  output bin valid
//   out_ready  in   downstream accepts the bin
//   out_data   out  {real, imag} of bin out_index
//   out_index  out  bin number 0..N-1
//   busy       out  high during COMPUTE and UNLOAD
//   ovf        out  sticky saturation flag for the current frame
//
// Build option
//   FFT_STAGE_SCALE_EN : each butterfly output is halved with rounding,
//                        so the result is DFT/N (IFFT becomes an exact inverse).
// -----------------------------------------------------------------------------
module fft_iter_engine #(
    parameter int LOG2N   = 5,
    parameter int bits    = 16,
    parameter int fix_bit = 7
) (
    input  logic                clk_100,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*bits-1:0]   in_data,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*bits-1:0]   out_data,
    output logic [LOG2N-1:0]    out_index,
    output logic                busy,
    output logic                ovf
);

    localparam int  N    = 1 << LOG2N;
    localparam int  HALF = N / 2;
    // Wide enough for a full complex product sum plus rounding without overflow.
    localparam int  PW   = 2 * bits + 2;
    localparam real PI   = 3.14159265358979323846;
    localparam real TW_SCALE = real'(1 << fix_bit);

    localparam logic signed [PW-1:0] RND   = PW'(1) <<< (fix_bit - 1);
    localparam logic signed [PW-1:0] MAX_X = (PW'(1) <<< (bits - 1)) - PW'(1);
    localparam logic signed [PW-1:0] MIN_X = -(PW'(1) <<< (bits - 1));
    localparam logic [bits-1:0]      MAX_B = {1'b0, {(bits-1){1'b1}}};
    localparam logic [bits-1:0]      MIN_B = {1'b1, {(bits-1){1'b0}}};

    typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

    // ---------------------------------------------------------------- helpers
    function automatic int round_real(input real x);
        round_real = (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        for (int i = 0; i < LOG2N; i++) begin
            bitrev[i] = x[LOG2N-1-i];
        end
    endfunction

    // Returns {saturated, value}.
    function automatic logic [bits:0] sat_f(input logic signed [PW-1:0] x);
        if (x > MAX_X) begin
            sat_f = {1'b1, MAX_B};
        end else if (x < MIN_X) begin
            sat_f = {1'b1, MIN_B};
        end else begin
            sat_f = {1'b0, x[bits-1:0]};
        end
    endfunction

    function automatic logic signed [PW-1:0] stage_scale(input logic signed [PW-1:0] x);
`ifdef FFT_STAGE_SCALE_EN
        stage_scale = (x + PW'(1)) >>> 1;
`else
        stage_scale = x;
`endif
    endfunction

    // ------------------------------------------------------------ twiddle ROM
    // Only k in 0..N/2-1 is ever addressed; the sign of the sine term is
    // applied in the butterfly according to the frame direction.
    logic signed [bits-1:0] tw_cos [HALF];
    logic signed [bits-1:0] tw_sin [HALF];

    generate
        for (genvar gi = 0; gi < HALF; gi++) begin : g_tw
            localparam real ANG = 2.0 * PI * real'(gi) / real'(N);
            assign tw_cos[gi] = bits'(round_real($cos(ANG) * TW_SCALE));
            assign tw_sin[gi] = bits'(round_real($sin(ANG) * TW_SCALE));
        end
    endgenerate

    // ------------------------------------------------------------- state
    state_t             state_q,     state_d;
    logic [LOG2N-1:0]   load_cnt_q,  load_cnt_d;
    logic [LOG2N-2:0]   bfly_q,      bfly_d;
    logic [3:0]         stage_q,     stage_d;
    logic               inv_q,       inv_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [2*bits-1:0]  out_data_q,  out_data_d;
    logic [LOG2N-1:0]   out_index_q, out_index_d;
    logic               busy_q,      busy_d;
    logic               ovf_q,       ovf_d;

    logic [2*bits-1:0]  store_q [N];

    // Store write ports (port b only used by the butterfly).
    logic               we_a, we_b;
    logic [LOG2N-1:0]   wa_addr, wb_addr;
    logic [2*bits-1:0]  wa_data, wb_data;

    // ---------------------------------------------------- butterfly datapath
    logic [LOG2N-1:0]       j_ext, h_bit, h_mask, addr_a, addr_b;
    logic [3:0]             tw_shift;
    logic [LOG2N-2:0]       tw_idx;
    logic [2*bits-1:0]      word_a, word_b;
    logic signed [bits-1:0] ar, ai, br, bi, wr, wi;
    logic signed [PW-1:0]   ar_x, ai_x, br_x, bi_x, wr_x, wi_x;
    logic signed [PW-1:0]   pr, pi;
    logic signed [bits-1:0] tr, ti;
    logic signed [PW-1:0]   tr_x, ti_x;
    logic signed [bits-1:0] an_re, an_im, bn_re, bn_im;
    logic [5:0]             sat_flag;
    logic                   sat_any;

    always_comb begin
        // Butterfly pair for stage s, counter j: a = (j>>s)*2h + (j&(h-1)), b = a+h.
        j_ext    = {1'b0, bfly_q};
        h_bit    = LOG2N'(1) << stage_q;
        h_mask   = h_bit - LOG2N'(1);
        addr_a   = ((j_ext >> stage_q) << (stage_q + 4'd1)) | (j_ext & h_mask);
        addr_b   = addr_a | h_bit;
        tw_shift = 4'(LOG2N - 1) - stage_q;
        tw_idx   = (bfly_q & h_mask[LOG2N-2:0]) << tw_shift;

        word_a = store_q[addr_a];
        word_b = store_q[addr_b];
        ar = word_a[2*bits-1:bits];
        ai = word_a[bits-1:0];
        br = word_b[2*bits-1:bits];
        bi = word_b[bits-1:0];
        wr = tw_cos[tw_idx];
        wi = inv_q ? tw_sin[tw_idx] : -tw_sin[tw_idx];

        ar_x = ar;  ai_x = ai;
        br_x = br;  bi_x = bi;
        wr_x = wr;  wi_x = wi;

        // t = B*W, rounded back to fix_bit fractional bits.
        pr = br_x * wr_x - bi_x * wi_x + RND;
        pi = br_x * wi_x + bi_x * wr_x + RND;
        {sat_flag[0], tr} = sat_f(pr >>> fix_bit);
        {sat_flag[1], ti} = sat_f(pi >>> fix_bit);
        tr_x = tr;
        ti_x = ti;

        {sat_flag[2], an_re} = sat_f(stage_scale(ar_x + tr_x));
        {sat_flag[3], an_im} = sat_f(stage_scale(ai_x + ti_x));
        {sat_flag[4], bn_re} = sat_f(stage_scale(ar_x - tr_x));
        {sat_flag[5], bn_im} = sat_f(stage_scale(ai_x - ti_x));
        sat_any = |sat_flag;
    end

    // ---------------------------------------------------------- control
    logic [LOG2N-1:0] next_index;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        bfly_d      = bfly_q;
        stage_d     = stage_q;
        inv_d       = inv_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        busy_d      = busy_q;
        ovf_d       = ovf_q;
        we_a        = 1'b0;
        we_b        = 1'b0;
        wa_addr     = '0;
        wb_addr     = '0;
        wa_data     = '0;
        wb_data     = '0;
        next_index  = out_index_q + LOG2N'(1);

        case (state_q)
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    we_a       = 1'b1;
                    wa_addr    = bitrev(load_cnt_q);
                    wa_data    = in_data;
                    load_cnt_d = load_cnt_q + LOG2N'(1);
                    if (load_cnt_q == '0) begin
                        inv_d = in_inv;
                        ovf_d = 1'b0;
                    end
                    if (load_cnt_q == '1) begin
                        state_d    = ST_COMPUTE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
            end

            ST_COMPUTE: begin
                we_a    = 1'b1;
                we_b    = 1'b1;
                wa_addr = addr_a;
                wb_addr = addr_b;
                wa_data = {an_re, an_im};
                wb_data = {bn_re, bn_im};
                if (sat_any) begin
                    ovf_d = 1'b1;
                end
                bfly_d = bfly_q + 1'b1;
                if (bfly_q == '1) begin
                    stage_d = stage_q + 4'd1;
                    if (stage_q == 4'(LOG2N - 1)) begin
                        stage_d = 4'd0;
                        state_d = ST_UNLOAD;
                    end
                end
            end

            ST_UNLOAD: begin
                // The first UNLOAD cycle fetches bin 0 after the final
                // butterfly has landed in the store.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = store_q[out_index_q];
                end else if (out_ready) begin
                    if (out_index_q == '1) begin
                        state_d     = ST_LOAD;
                        out_valid_d = 1'b0;
                        out_index_d = '0;
                        busy_d      = 1'b0;
                        in_ready_d  = 1'b1;
                    end else begin
                        out_index_d = next_index;
                        out_data_d  = store_q[next_index];
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            bfly_q      <= '0;
            stage_q     <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            bfly_q      <= bfly_d;
            stage_q     <= stage_d;
            inv_q       <= inv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    // Working store: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk_100) begin
        if (we_a) begin
            store_q[wa_addr] <= wa_data;
        end
        if (we_b) begin
            store_q[wb_addr] <= wb_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_iter_engine.sv
// -----------------------------------------------------------------------------
// tb_fft_iter_engine
// Directed frames for the 32-point engine: impulse, DC, shifted impulse
// (forward and inverse), saturation, output backpressure, and reset in the
// middle of COMPUTE. Expected values are hand-derived DFT results.
// -----------------------------------------------------------------------------
module tb_fft_iter_engine;

    localparam int LOG2N = 5;
    localparam int BITS  = 16;
    localparam int FIX   = 7;
    localparam int N     = 1 << LOG2N;
    localparam int LAT   = LOG2N * N / 2 + 1;

`ifdef FFT_STAGE_SCALE_EN
    localparam int A_IMP   = 4;     // impulse of 128 scaled by 1/N
    localparam int A_DC    = 128;   // 32 * 128 / 32
    localparam int SAT_OVF = 0;     // halving every stage keeps the DC sum in range
`else
    localparam int A_IMP   = 128;
    localparam int A_DC    = 4096;
    localparam int SAT_OVF = 1;
`endif

    logic                 clk_100 = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*BITS-1:0]    in_data;
    logic                 in_inv;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*BITS-1:0]    out_data;
    logic [LOG2N-1:0]     out_index;
    logic                 busy;
    logic                 ovf;

    int n_checks = 0;
    int n_errors = 0;
    int frame_no = 0;

    int smp_re [N];
    int smp_im [N];
    int bin_re [N];
    int bin_im [N];

    fft_iter_engine #(
        .LOG2N   (LOG2N),
        .bits    (BITS),
        .fix_bit (FIX)
    ) dut (
        .clk_100   (clk_100),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk_100 = ~clk_100;

    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        int d;
        n_checks++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic clear_samples();
        for (int k = 0; k < N; k++) begin
            smp_re[k] = 0;
            smp_im[k] = 0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_in_ready"},  int'(in_ready),  1, 0);
        check_val({tag, "_out_valid"}, int'(out_valid), 0, 0);
        check_val({tag, "_out_data"},  int'(out_data),  0, 0);
        check_val({tag, "_out_index"}, int'(out_index), 0, 0);
        check_val({tag, "_busy"},      int'(busy),      0, 0);
        check_val({tag, "_ovf"},       int'(ovf),       0, 0);
    endtask

    task automatic send_frame(input logic inv, input bit chk_ovf_clear);
        int guard;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_inv   = inv;
            in_data  = {BITS'(smp_re[k]), BITS'(smp_im[k])};
            guard    = 0;
            while (!in_ready && guard < 1000) begin
                @(negedge clk_100);
                guard++;
            end
            if (guard >= 1000) check_val("load_timeout", guard, 0, 0);
            @(posedge clk_100);
            #1;
            if (k == 0 && chk_ovf_clear) check_val("ovf_clear_first", int'(ovf), 0, 0);
        end
        // Stray traffic while the engine is busy must be ignored.
        in_valid = 1'b1;
        in_inv   = ~inv;
        in_data  = 32'h4000_4000;
    endtask

    task automatic collect(input int bp_idx);
        int cnt, guard, stable_bad, order_bad;
        logic [2*BITS-1:0] hd;
        logic [LOG2N-1:0]  hi;
        cnt = 0; guard = 0; order_bad = 0;
        out_ready = 1'b1;
        while (cnt < N && guard < 3000) begin
            @(negedge clk_100);
            guard++;
            if (out_valid) begin
                in_valid = 1'b0;
                if (cnt == bp_idx) begin
                    out_ready  = 1'b0;
                    hd         = out_data;
                    hi         = out_index;
                    stable_bad = 0;
                    repeat (10) begin
                        @(negedge clk_100);
                        if (out_data !== hd || out_index !== hi || out_valid !== 1'b1) stable_bad++;
                    end
                    check_val("bp_stable", stable_bad, 0, 0);
                    check_val("bp_index", int'(out_index), bp_idx, 0);
                    out_ready = 1'b1;
                end
                if (int'(out_index) != cnt) order_bad++;
                bin_re[out_index] = int'($signed(out_data[2*BITS-1:BITS]));
                bin_im[out_index] = int'($signed(out_data[BITS-1:0]));
                cnt++;
            end
        end
        check_val("unload_count", cnt, N, 0);
        check_val("unload_order", order_bad, 0, 0);
        @(posedge clk_100);
        #1;
    endtask

    task automatic run_frame(input logic inv, input bit chk_ovf_clear, input int bp_idx);
        int lat;
        send_frame(inv, chk_ovf_clear);
        check_val("compute_in_ready", int'(in_ready), 0, 0);
        check_val("compute_busy", int'(busy), 1, 0);
        lat = 0;
        while (!out_valid && lat < 5000) begin
            @(posedge clk_100);
            #1;
            lat++;
        end
        check_val("latency", lat, LAT, 0);
        collect(bp_idx);
        check_val("post_in_ready", int'(in_ready), 1, 0);
        check_val("post_busy", int'(busy), 0, 0);
        check_val("post_out_valid", int'(out_valid), 0, 0);
        frame_no++;
        $display("frame %0d: inv=%0d latency=%0d bin0=(%0d,%0d) ovf=%0d",
                 frame_no, inv, lat, bin_re[0], bin_im[0], ovf);
    endtask

    task automatic check_impulse(input string tag);
        for (int k = 0; k < N; k++) begin
            check_val($sformatf("%s_re[%0d]", tag, k), bin_re[k], A_IMP, 0);
            check_val($sformatf("%s_im[%0d]", tag, k), bin_im[k], 0, 0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk_100);
        #1;
        reset = 1'b0;
        check_reset_state("reset");

        // Impulse at x[0], forward.
        clear_samples();
        smp_re[0] = 128;
        run_frame(1'b0, 1'b0, -1);
        check_impulse("imp");
        check_val("imp_ovf", int'(ovf), 0, 0);

        // DC input, forward.
        for (int k = 0; k < N; k++) smp_re[k] = 128;
        run_frame(1'b0, 1'b0, -1);
        check_val("dc_re[0]", bin_re[0], A_DC, 0);
        check_val("dc_im[0]", bin_im[0], 0, 0);
        for (int k = 1; k < N; k++) begin
            check_val($sformatf("dc_re[%0d]", k), bin_re[k], 0, 1);
            check_val($sformatf("dc_im[%0d]", k), bin_im[k], 0, 1);
        end
        check_val("dc_ovf", int'(ovf), 0, 0);

        // Impulse at x[1], forward, with backpressure at bin 3.
        clear_samples();
        smp_re[1] = 128;
        run_frame(1'b0, 1'b0, 3);
        check_val("shf_re[0]",  bin_re[0],  A_IMP, 1);
        check_val("shf_im[0]",  bin_im[0],  0, 1);
        check_val("shf_re[8]",  bin_re[8],  0, 1);
        check_val("shf_im[8]",  bin_im[8],  -A_IMP, 1);
        check_val("shf_re[16]", bin_re[16], -A_IMP, 1);
        check_val("shf_im[16]", bin_im[16], 0, 1);
        check_val("shf_re[24]", bin_re[24], 0, 1);
        check_val("shf_im[24]", bin_im[24], A_IMP, 1);
        check_val("shf_ovf", int'(ovf), 0, 0);

        // Same input, inverse: the rotation direction flips.
        run_frame(1'b1, 1'b0, -1);
        check_val("inv_re[8]",  bin_re[8],  0, 1);
        check_val("inv_im[8]",  bin_im[8],  A_IMP, 1);
        check_val("inv_re[16]", bin_re[16], -A_IMP, 1);
        check_val("inv_im[24]", bin_im[24], -A_IMP, 1);

        // Full-scale DC saturates the accumulation.
        for (int k = 0; k < N; k++) smp_re[k] = 32767;
        run_frame(1'b0, 1'b0, -1);
        check_val("sat_re[0]", bin_re[0], 32767, 0);
        check_val("sat_im[0]", bin_im[0], 0, 0);
        check_val("sat_ovf", int'(ovf), SAT_OVF, 0);

        // Clean frame: ovf clears on its first sample.
        clear_samples();
        smp_re[0] = 128;
        run_frame(1'b0, 1'b1, -1);
        check_val("clean_re[0]", bin_re[0], A_IMP, 0);
        check_val("clean_ovf", int'(ovf), 0, 0);

        // Reset in the middle of COMPUTE.
        for (int k = 0; k < N; k++) smp_re[k] = 32767;
        send_frame(1'b0, 1'b0);
        repeat (40) @(posedge clk_100);
        #1;
        check_val("mid_busy", int'(busy), 1, 0);
        check_val("mid_ovf", int'(ovf), SAT_OVF, 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk_100);
        #1;
        reset = 1'b0;
        check_reset_state("abort");
        $display("frame abort: reset applied during COMPUTE");

        // Impulse frame after the abort.
        clear_samples();
        smp_re[0] = 128;
        run_frame(1'b0, 1'b0, -1);
        check_impulse("rst_imp");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
